// File: rtl/norm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | norm_pkg                                                             |
// | Shared constants and channel packing helper for the normaliser.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package norm_pkg;

  // Cycles from an accepting edge to the edge that raises out_valid.
  localparam int NORM_LATENCY = 3;

  // Widest packed bus the slice helper accepts.
  localparam int NORM_MAX_BUS = 1024;

  // Extract channel i_idx of width i_width from a packed bus (channel 0 at LSBs).
  function automatic logic [63:0] chan_slice(input logic [NORM_MAX_BUS-1:0] i_bus,
                                             input int i_idx,
                                             input int i_width);
    logic [63:0] w_mask;
    w_mask = (i_width >= 64) ? '1 : ((64'd1 << i_width) - 64'd1);
    return 64'(i_bus >> (i_idx * i_width)) & w_mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lod_norm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lod_norm                                                             |
// | Leading-one detector: left shift needed to bring the MSB to the top. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module lod_norm
  import norm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  i_z,
  output logic [SHIFT_WIDTH-1:0] o_sh
);

  logic [SHIFT_WIDTH-1:0] w_msb;

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i_z[i]) w_msb = SHIFT_WIDTH'(i);
    end
  end

  assign o_sh = SHIFT_WIDTH'(DATA_WIDTH - 1) - w_msb;

endmodule
`default_nettype wire

// File: rtl/norm_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | norm_pipe                                                            |
// | Multi-channel pipelined leading-one normaliser with per-channel or   |
// | shared (block floating point) shift. Ranks: capture, detect,         |
// | min-tree, shift/output. One global enable stalls every rank.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module norm_pipe
  import norm_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int CHANNELS      = 4,
  parameter int MIN_THRESHOLD = 1,
  parameter int SHIFT_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            block_mode,
  input  logic [CHANNELS*DATA_WIDTH-1:0]  data_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]  data_out,
  output logic [CHANNELS*SHIFT_WIDTH-1:0] shift_out,
  output logic [CHANNELS-1:0]             zero_flag
);

  logic w_en;

  // Valid chain
  logic r_s0_v, r_s1_v, r_s2_v, r_out_valid;

  // Datapath ranks (not reset; qualified by the valid chain)
  logic [DATA_WIDTH-1:0]  w_z     [CHANNELS];
  logic [CHANNELS-1:0]    w_zf;
  logic [DATA_WIDTH-1:0]  r_s0_z  [CHANNELS];
  logic [CHANNELS-1:0]    r_s0_zf;
  logic                   r_s0_mode;
  logic [SHIFT_WIDTH-1:0] w_sh    [CHANNELS];
  logic [DATA_WIDTH-1:0]  r_s1_z  [CHANNELS];
  logic [SHIFT_WIDTH-1:0] r_s1_sh [CHANNELS];
  logic [CHANNELS-1:0]    r_s1_zf;
  logic                   r_s1_mode;
  logic [SHIFT_WIDTH-1:0] w_shmin;
  logic [DATA_WIDTH-1:0]  r_s2_z  [CHANNELS];
  logic [SHIFT_WIDTH-1:0] r_s2_sh [CHANNELS];
  logic [SHIFT_WIDTH-1:0] r_s2_shmin;
  logic [CHANNELS-1:0]    r_s2_zf;
  logic                   r_s2_mode;

  // Next output values
  logic [CHANNELS*DATA_WIDTH-1:0]  w_data_nxt;
  logic [CHANNELS*SHIFT_WIDTH-1:0] w_shift_nxt;

  // Output registers
  logic [CHANNELS*DATA_WIDTH-1:0]  r_data_out;
  logic [CHANNELS*SHIFT_WIDTH-1:0] r_shift_out;
  logic [CHANNELS-1:0]             r_zero_flag;

  // Whole pipe advances when the output slot is empty or being drained.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  genvar gc;
  generate
    for (gc = 0; gc < CHANNELS; gc++) begin : g_ch
      logic [DATA_WIDTH-1:0]  w_x;
      logic [SHIFT_WIDTH-1:0] w_amt;

      assign w_x      = data_in[gc*DATA_WIDTH +: DATA_WIDTH];
      assign w_zf[gc] = (w_x == '0);
      assign w_z[gc]  = w_zf[gc] ? DATA_WIDTH'(MIN_THRESHOLD) : w_x;

      lod_norm #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
      ) u_lod (
        .i_z  (r_s0_z[gc]),
        .o_sh (w_sh[gc])
      );

      // Shared shift never exceeds a channel's own shift, so no bits drop.
      assign w_amt = r_s2_mode ? r_s2_shmin : r_s2_sh[gc];
      assign w_data_nxt[gc*DATA_WIDTH +: DATA_WIDTH]    = r_s2_z[gc] << w_amt;
      assign w_shift_nxt[gc*SHIFT_WIDTH +: SHIFT_WIDTH] = w_amt;
    end
  endgenerate

  // Minimum shift across channels for block mode.
  always_comb begin
    w_shmin = r_s1_sh[0];
    for (int c = 1; c < CHANNELS; c++) begin
      if (r_s1_sh[c] < w_shmin) w_shmin = r_s1_sh[c];
    end
  end

  // Valid shift chain; bubbles travel as invalid slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_v      <= 1'b0;
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_s0_v      <= in_valid;
      r_s1_v      <= r_s0_v;
      r_s2_v      <= r_s1_v;
      r_out_valid <= r_s2_v;
    end
  end

  // Datapath ranks: capture/substitute, detect, min-tree.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s0_zf    <= w_zf;
      r_s0_mode  <= block_mode;
      r_s1_zf    <= r_s0_zf;
      r_s1_mode  <= r_s0_mode;
      r_s2_zf    <= r_s1_zf;
      r_s2_mode  <= r_s1_mode;
      r_s2_shmin <= w_shmin;
      for (int c = 0; c < CHANNELS; c++) begin
        r_s0_z[c]  <= w_z[c];
        r_s1_z[c]  <= r_s0_z[c];
        r_s1_sh[c] <= w_sh[c];
        r_s2_z[c]  <= r_s1_z[c];
        r_s2_sh[c] <= r_s1_sh[c];
      end
    end
  end

  // Output rank: loads only real beats so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out  <= '0;
      r_shift_out <= '0;
      r_zero_flag <= '0;
    end else if (w_en && r_s2_v) begin
      r_data_out  <= w_data_nxt;
      r_shift_out <= w_shift_nxt;
      r_zero_flag <= r_s2_zf;
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign shift_out = r_shift_out;
  assign zero_flag = r_zero_flag;

endmodule
`default_nettype wire
